// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Purpose : Load-use stall and taken-branch flush control for the five-stage
//           LEGv8 pipeline, with saturating debug event counters.
// Revision: 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      ifid_instruction,
    input  logic             reg2loc,
    input  logic             idex_memread,
    input  logic [4:0]       idex_write_reg,
    input  logic             exmem_pcsrc,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             bubble_in_ex,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [4:0]       c_xzr     = 5'd31;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state_q;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_stall_cnt_q;
    logic [CNT_W-1:0] w_stall_cnt_d;
    logic [CNT_W-1:0] r_flush_cnt_q;
    logic [CNT_W-1:0] w_flush_cnt_d;

    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_lu;
    logic       w_br;
    logic       w_stall;

    always_comb begin
        w_rs1   = ifid_instruction[9:5];
        w_rs2   = reg2loc ? ifid_instruction[4:0] : ifid_instruction[20:16];
        w_lu    = idex_memread && (idex_write_reg != c_xzr) &&
                  ((idex_write_reg == w_rs1) || (idex_write_reg == w_rs2));
        w_br    = exmem_pcsrc;
        // A taken branch squashes the dependent instruction, so it overrides the stall.
        w_stall = w_lu && !w_br;
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        w_state_d   = ST_RUN;

        if (w_br) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            w_state_d   = ST_FLUSH;
        end else if (w_lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            w_state_d   = ST_STALL;
        end
    end

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (w_stall && (r_stall_cnt_q != c_cnt_max)) begin
            w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
        end
        if (w_br && (r_flush_cnt_q != c_cnt_max)) begin
            w_flush_cnt_d = r_flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q     <= ST_RUN;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign bubble_in_ex = (r_state_q != ST_RUN);
    assign stall_count  = r_stall_cnt_q;
    assign flush_count  = r_flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Purpose : Directed and randomized checks of hazard_ctrl at CNT_W=16 and 4.
// Revision: 1.0
// ============================================================================
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ifid_instruction = '0;
    logic        reg2loc = 1'b0;
    logic        idex_memread = 1'b0;
    logic [4:0]  idex_write_reg = '0;
    logic        exmem_pcsrc = 1'b0;

    logic        a_pc_write, a_ifid_write, a_idex_bubble;
    logic        a_ifid_flush, a_idex_flush, a_exmem_flush, a_bubble_in_ex;
    logic [15:0] a_stall_count, a_flush_count;
    logic        b_pc_write, b_ifid_write, b_idex_bubble;
    logic        b_ifid_flush, b_idex_flush, b_exmem_flush, b_bubble_in_ex;
    logic [3:0]  b_stall_count, b_flush_count;

    int checks = 0;
    int failures = 0;

    // Reference state: did an event happen last cycle, and how many of each so far.
    logic m_event = 1'b0;
    int   m_stalls = 0;
    int   m_flushes = 0;

    always #5 clock = ~clock;

    hazard_ctrl #(.CNT_W(16)) u_dut_a (
        .clock(clock), .reset(reset), .ifid_instruction(ifid_instruction),
        .reg2loc(reg2loc), .idex_memread(idex_memread), .idex_write_reg(idex_write_reg),
        .exmem_pcsrc(exmem_pcsrc), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
        .idex_bubble(a_idex_bubble), .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
        .exmem_flush(a_exmem_flush), .bubble_in_ex(a_bubble_in_ex),
        .stall_count(a_stall_count), .flush_count(a_flush_count)
    );

    hazard_ctrl #(.CNT_W(4)) u_dut_b (
        .clock(clock), .reset(reset), .ifid_instruction(ifid_instruction),
        .reg2loc(reg2loc), .idex_memread(idex_memread), .idex_write_reg(idex_write_reg),
        .exmem_pcsrc(exmem_pcsrc), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
        .idex_bubble(b_idex_bubble), .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
        .exmem_flush(b_exmem_flush), .bubble_in_ex(b_bubble_in_ex),
        .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check_regs();
        chk("a_bubble_in_ex", {31'd0, a_bubble_in_ex}, {31'd0, m_event});
        chk("b_bubble_in_ex", {31'd0, b_bubble_in_ex}, {31'd0, m_event});
        chk("a_stall_count", {16'd0, a_stall_count}, sat(m_stalls, 65535));
        chk("a_flush_count", {16'd0, a_flush_count}, sat(m_flushes, 65535));
        chk("b_stall_count", {28'd0, b_stall_count}, sat(m_stalls, 15));
        chk("b_flush_count", {28'd0, b_flush_count}, sat(m_flushes, 15));
    endtask

    // One clock: check registered outputs, drive inputs, check Mealy outputs, advance model.
    task automatic step(input logic [31:0] ins, input logic r2l, input logic mr,
                        input logic [4:0] wr, input logic pcs, input logic rst);
        int  rs1, rs2, dst;
        bit  hazard, stall, flush;
        logic [5:0] exp_ctl;
        @(negedge clock);
        check_regs();
        ifid_instruction = ins;
        reg2loc          = r2l;
        idex_memread     = mr;
        idex_write_reg   = wr;
        exmem_pcsrc      = pcs;
        reset            = rst;
        #1;
        rs1    = int'(ins[9:5]);
        rs2    = r2l ? int'(ins[4:0]) : int'(ins[20:16]);
        dst    = int'(wr);
        hazard = mr && (dst != 31) && (dst == rs1 || dst == rs2);
        flush  = pcs;
        stall  = hazard && !flush;
        // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush}
        exp_ctl = {!stall, !stall, stall, flush, flush, flush};
        chk("a_ctl", {26'd0, a_pc_write, a_ifid_write, a_idex_bubble,
                      a_ifid_flush, a_idex_flush, a_exmem_flush}, {26'd0, exp_ctl});
        chk("b_ctl", {26'd0, b_pc_write, b_ifid_write, b_idex_bubble,
                      b_ifid_flush, b_idex_flush, b_exmem_flush}, {26'd0, exp_ctl});
        if (rst) begin
            m_event   = 1'b0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            m_event   = stall || flush;
            m_stalls  = m_stalls + (stall ? 1 : 0);
            m_flushes = m_flushes + (flush ? 1 : 0);
        end
    endtask

    function automatic logic [31:0] mk(input int f95, input int f40, input int f2016);
        logic [31:0] v;
        v        = 32'h8B00_0000;
        v[9:5]   = 5'(f95);
        v[4:0]   = 5'(f40);
        v[20:16] = 5'(f2016);
        return v;
    endfunction

    initial begin
        // Reset held for two cycles
        step(mk(0, 0, 0), 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        step(mk(0, 0, 0), 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        step(mk(1, 2, 3), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Load then use via rs1
        step(mk(5, 1, 2), 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step(mk(5, 1, 2), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Second source selection by reg2loc
        step(mk(1, 7, 3), 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        step(mk(1, 2, 7), 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        step(mk(1, 7, 3), 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);

        // XZR destination and non-load never stall
        step(mk(31, 31, 31), 1'b0, 1'b1, 5'd31, 1'b0, 1'b0);
        step(mk(5, 5, 5), 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);

        // Branch beats load-use in the same cycle
        step(mk(5, 1, 2), 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
        step(mk(1, 2, 3), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Back-to-back branches: the 4-bit counters saturate at 15
        for (int i = 0; i < 20; i++) begin
            step(mk(i, 2, 3), 1'b0, 1'b1, 5'(i), 1'b1, 1'b0);
        end

        // Reset in the middle of a stall run
        step(mk(0, 0, 0), 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(mk(9, 1, 2), 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        end
        step(mk(9, 1, 2), 1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
        step(mk(1, 2, 3), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Randomized traffic over a narrow register range so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            int w;
            logic [31:0] ins;
            ins      = $urandom;
            ins[9:5] = 5'($urandom_range(0, 7));
            ins[4:0] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            w = $urandom_range(0, 8);
            step(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 (w == 8) ? 5'd31 : 5'(w), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 60) == 0));
        end

        @(negedge clock);
        check_regs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage LEGv8 CPU. It sits on the read side of the ID/EX register. It compares the instruction in decode against the ID/EX load destination and inserts a one-cycle load-use stall. It also flushes the three younger stages when a taken branch resolves in MEM, and keeps saturating stall/flush event counters for debug.

## Interface
- Parameters:
  - `CNT_W`, default 16: width of the event counters.
- Ports:
  - `clock` in 1: sole clock; all state updates on the rising edge.
  - `reset` in 1: synchronous, active-high reset.
  - `ifid_instruction` in 32: instruction currently in decode (IF/ID output).
  - `reg2loc` in 1: decode control. 1 means the second source is [4:0] (STUR/CBZ); 0 means [20:16].
  - `idex_memread` in 1: Memread output of ID/EX.
  - `idex_write_reg` in 5: write_reg output of ID/EX.
  - `exmem_pcsrc` in 1: taken branch resolved in MEM, i.e. (Branch & zero) | Uncond_Branch.
  - `pc_write` out 1: PC load enable.
  - `ifid_write` out 1: IF/ID load enable.
  - `idex_bubble` out 1: selects zero for every ID/EX control input (aluOp, aluSrc, branch, uncond_branch, memread, memwrite, regWrite, memtoReg).
  - `ifid_flush`, `idex_flush`, `exmem_flush` out 1 each: clear the control fields of the named register at the next edge.
  - `bubble_in_ex` out 1: registered; the instruction now in EX is a hazard bubble.
  - `stall_count` out CNT_W: number of load-use stalls, saturating.
  - `flush_count` out CNT_W: number of branch flushes, saturating.

## Operation
- Source fields: `rs1` = `ifid_instruction[9:5]`. `rs2` = `reg2loc ? ifid_instruction[4:0] : ifid_instruction[20:16]`.
- Load-use detection: `lu = idex_memread & (idex_write_reg != 5'd31) & (idex_write_reg == rs1 | idex_write_reg == rs2)`. X31 (XZR) never causes a hazard.
- Branch detection: `br = exmem_pcsrc`. Branch takes priority over load-use; with `br` set, `lu` is ignored.
- Outputs are Mealy (combinational from state and inputs):
  - Default: `pc_write`=1, `ifid_write`=1, all other control outputs 0.
  - `lu` & !`br`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
  - `br`: `ifid_flush`=`idex_flush`=`exmem_flush`=1, `pc_write`=1, `ifid_write`=1.
- FSM states (encoding is free):
  - RUN: no event in the previous cycle.
  - STALL: a load-use bubble was inserted in the previous cycle.
  - FLUSH: a branch flush occurred in the previous cycle.
- Transitions, evaluated every edge:
  - `br` goes to FLUSH.
  - else `lu` goes to STALL.
  - else goes to RUN.
  - A state may transition to itself; back-to-back events are legal.
- `bubble_in_ex` = 1 in STALL or FLUSH, 0 in RUN.
- Counters:
  - `stall_count` increments on each edge where `lu` & !`br`.
  - `flush_count` increments on each edge where `br`.
  - Both saturate at all-ones and never wrap.
- Reset, including mid-stall or mid-flush: state=RUN, `bubble_in_ex`=0, both counters 0. While `reset` is high, control outputs still follow the combinational rules above.

## Timing
- Zero-cycle latency from inputs to the pipeline control outputs.
- Load-use costs exactly 1 cycle:
  - At the edge with `lu`, PC and IF/ID hold and ID/EX loads a bubble.
  - At the next edge, the load has moved to EX/MEM, `idex_memread`=0, and decode proceeds.
- Branch flush costs 3 younger instructions. The PC mux switches to the target at the same edge the flush is applied.
- A load-use and a taken branch in the same cycle: only the flush is applied and only `flush_count` increments.
- Registered outputs (`bubble_in_ex`, counters) update one edge after the triggering cycle.

## Test plan
- Load then use:
  - Stimulus: `idex_memread`=1, `idex_write_reg`=5, instruction with [9:5]=5, `exmem_pcsrc`=0.
  - Response: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1 that cycle; next cycle `bubble_in_ex`=1 and `stall_count`=1.
- Second-source match on a store:
  - Stimulus: `reg2loc`=1, [4:0]=7, [20:16]=3, `idex_write_reg`=7, `idex_memread`=1.
  - Response: stall asserted.
  - Repeat with `reg2loc`=0 and [20:16]=7: stall asserted. With `reg2loc`=0 and [20:16]=3: no stall.
- XZR and non-load:
  - Stimulus: `idex_write_reg`=31 with a matching rs1, `idex_memread`=1. Then `idex_write_reg`=5 matching, `idex_memread`=0.
  - Response: no stall in either case; `stall_count` stays 0.
- Branch priority:
  - Stimulus: `lu` and `exmem_pcsrc` both 1 in the same cycle.
  - Response: all three flushes =1, `pc_write`=1, `idex_bubble`=0; `flush_count`=1, `stall_count`=0; state FLUSH.
- Saturation:
  - Stimulus: `CNT_W`=4, hold `exmem_pcsrc`=1 for 20 cycles.
  - Response: `flush_count` reaches 15 and stays at 15; `bubble_in_ex` stays 1.
- Reset mid-operation:
  - Stimulus: assert `reset` for 1 cycle while in STALL with `stall_count`=3.
  - Response: next cycle state RUN, `bubble_in_ex`=0, both counters 0.
